alu_arbiter: RTL and testbench

- Shares one ALU instance between NREQ independent requesters, e.g. the CPU decode stage and a debug/DMA port.
- Arbitration is round-robin. Each requester holds a request with its operands, receives a one-hot grant, then a one-cycle done pulse with the result and flags.
- Owns the ALU instance, the operand registers and the result-capture timing. The ALU's one-clock registered latency is hidden from requesters.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu.sv | 26 ++
 rtl/alu_arbiter_rr_pick.sv | 30 +++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: opcodes, flag bit masks, arbiter states.
package alu_pkg;

  typedef enum logic [3:0] {
    HALT = 4'd0,
    ADD  = 4'd1,
    SUB  = 4'd2,
    CMP  = 4'd3
  } opcode_e;

  // Flag bit positions inside the 4-bit {V,C,N,Z} flag word.
  localparam logic [3:0] FLAG_Z = 4'b0001;
  localparam logic [3:0] FLAG_N = 4'b0010;
  localparam logic [3:0] FLAG_C = 4'b0100;
  localparam logic [3:0] FLAG_V = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Small 8-bit ALU with one clock of registered latency and no reset.
// Only CMP writes the flag register; every other opcode leaves it alone.
module alu
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] out,
  output logic [3:0] flags
);

  // Register the result and, for CMP only, the {a<b, a==b} flags.
  always_ff @(posedge clk) begin
    case (op)
      ADD:     out <= a + b;
      SUB:     out <= a - b;
      default: out <= '0;
    endcase
    if (op == CMP) begin
      flags <= ((a < b) ? FLAG_N : 4'b0000) | ((a == b) ? FLAG_Z : 4'b0000);
    end
  end

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk the requesters starting just after the previous winner.
  always_comb begin
    int c;
    c   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(last) + k) % NREQ;
      if (!any && req[c[IDX_W-1:0]]) begin
        any                = 1'b1;
        gnt[c[IDX_W-1:0]]  = 1'b1;
        idx                = c[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters.
// Handshake: a requester raises req with stable operands; the arbiter answers
// with a one-hot gnt held until the cycle after done, and a one-cycle done
// pulse carrying result/flags_out. req is only looked at in IDLE, operands
// are registered when the grant is issued, and an operation never aborts.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] op_flat,
  input  logic [8*NREQ-1:0] a_flat,
  input  logic [8*NREQ-1:0] b_flat,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        result,
  output logic [3:0]        flags_out,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       state, state_next;
  logic [IDX_W-1:0] last_q;
  logic [NREQ-1:0]  pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [3:0]       alu_op;
  logic [7:0]       in1, in2;
  logic [7:0]       alu_out;
  logic [3:0]       alu_flags;
  logic [3:0]       op_sel;
  logic [7:0]       a_sel, b_sel;
  logic             load, capture, finish;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req  (req),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  alu u_alu (
    .clk   (clk),
    .op    (alu_op),
    .a     (in1),
    .b     (in2),
    .out   (alu_out),
    .flags (alu_flags)
  );

  // Route the picked requester's opcode and operands to the operand registers.
  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        op_sel = op_flat[4*i +: 4];
        a_sel  = a_flat[8*i +: 8];
        b_sel  = b_flat[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and per-state datapath strobes.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        capture    = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Operand registers, grant, result capture and completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      done      <= '0;
      result    <= '0;
      flags_out <= '0;
      op_count  <= '0;
      alu_op    <= HALT;
      in1       <= '0;
      in2       <= '0;
      last_q    <= IDX_W'(NREQ - 1);
    end else begin
      if (load) begin
        gnt    <= pick_gnt;
        alu_op <= op_sel;
        in1    <= a_sel;
        in2    <= b_sel;
        last_q <= pick_idx;
      end else if (state == IDLE) begin
        alu_op <= HALT;
      end
      if (capture) begin
        result    <= alu_out;
        flags_out <= alu_flags;
        done      <= gnt;
        if (op_count != '1) op_count <= op_count + CNT_W'(1);
      end
      if (finish) begin
        done   <= '0;
        gnt    <= '0;
        alu_op <= HALT;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by randomized contention,
// checked against a transaction-level model of the arbiter.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ  = 2;
  localparam int CNT_W = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] op_flat;
  logic [8*NREQ-1:0] a_flat;
  logic [8*NREQ-1:0] b_flat;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [7:0]        result;
  logic [3:0]        flags_out;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  alu_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_flat   (op_flat),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .gnt       (gnt),
    .done      (done),
    .result    (result),
    .flags_out (flags_out),
    .busy      (busy),
    .op_count  (op_count)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int         m_last;
  int         m_count;
  logic [3:0] m_flags;
  bit         m_flags_known = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input bit on, input logic [3:0] op,
                       input logic [7:0] a, input logic [7:0] b);
    req[r]           = on;
    op_flat[4*r +: 4] = op;
    a_flat[8*r +: 8]  = a;
    b_flat[8*r +: 8]  = b;
  endtask

  function automatic logic [7:0] model_result(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
    int r;
    case (op)
      4'd1:    r = (int'(a) + int'(b)) % 256;
      4'd2:    r = (int'(a) - int'(b) + 256) % 256;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  // Requesters are offered in rotation starting after the last winner.
  function automatic int model_winner(input logic [NREQ-1:0] rq);
    int order[$];
    for (int k = 1; k <= NREQ; k++) order.push_back((m_last + k) % NREQ);
    foreach (order[i]) if (rq[order[i]]) return order[i];
    return -1;
  endfunction

  task automatic model_reset();
    m_last  = NREQ - 1;
    m_count = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    step();
    step();
    model_reset();
    chk("rst_gnt", gnt, '0);
    chk("rst_done", done, '0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags_out, 0);
    chk("rst_count", op_count, 0);
    rst_n = 1'b1;
    step();
  endtask

  // Wait for the next grant and follow the operation through to its done pulse.
  task automatic serve(input string tag);
    int              w;
    logic [NREQ-1:0] oh;
    logic [3:0]      op;
    logic [7:0]      a, b, er;
    w  = model_winner(req);
    oh = '0;
    if (w < 0) w = 0;
    else       oh[w] = 1'b1;
    op = op_flat[4*w +: 4];
    a  = a_flat[8*w +: 8];
    b  = b_flat[8*w +: 8];
    er = model_result(op, a, b);
    for (int i = 0; i < 8 && gnt == '0; i++) step();
    chk($sformatf("%s_gnt", tag), gnt, oh);
    chk($sformatf("%s_busy", tag), busy, 1);
    chk($sformatf("%s_done_e0", tag), done, '0);
    // Operands were registered at the grant edge; later changes must not matter.
    drive(w, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    step();
    chk($sformatf("%s_done_e1", tag), done, '0);
    chk($sformatf("%s_gnt_e1", tag), gnt, oh);
    step();
    if (op == 4'd3) begin
      m_flags       = {2'b00, a < b, a == b};
      m_flags_known = 1;
    end
    if (m_count < (1 << CNT_W) - 1) m_count++;
    chk($sformatf("%s_done", tag), done, oh);
    chk($sformatf("%s_result", tag), result, er);
    chk($sformatf("%s_count", tag), op_count, m_count);
    if (m_flags_known) chk($sformatf("%s_flags", tag), flags_out, m_flags);
    req[w] = 1'b0;
    step();
    chk($sformatf("%s_done_e3", tag), done, '0);
    chk($sformatf("%s_gnt_e3", tag), gnt, '0);
    chk($sformatf("%s_busy_e3", tag), busy, 0);
    m_last = w;
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    op_flat = '0;
    a_flat  = '0;
    b_flat  = '0;
    do_reset();

    // Single requests, overflow wrap, subtract wrap.
    drive(0, 1, ADD, 8'h7F, 8'h01);
    serve("add_7f");
    drive(1, 1, SUB, 8'h05, 8'h07);
    serve("sub_wrap");

    // CMP sets flags; a following ADD returns the same flags.
    drive(0, 1, CMP, 8'd3, 8'd5);
    serve("cmp");
    chk("cmp_flags_lt", flags_out, 4'b0010);
    drive(0, 1, ADD, 8'd1, 8'd1);
    serve("add_after_cmp");
    chk("flags_persist", flags_out, 4'b0010);

    // Contention straight after reset: requester 0 first, then 1.
    do_reset();
    drive(0, 1, ADD, 8'd1, 8'd2);
    drive(1, 1, SUB, 8'd9, 8'd4);
    serve("cont_a");
    serve("cont_b");
    // Requester 0 was granted last, so requester 1 wins the next contention.
    drive(0, 1, ADD, 8'd10, 8'd20);
    serve("solo_r0");
    drive(0, 1, ADD, 8'd1, 8'd2);
    drive(1, 1, SUB, 8'd9, 8'd4);
    serve("cont_c");
    serve("cont_d");

    // Unsupported opcode still runs the full sequence with result zero.
    drive(0, 1, 4'h9, 8'h33, 8'h44);
    serve("bad_op");

    // Reset while the operation is in WAIT.
    drive(0, 1, ADD, 8'd2, 8'd2);
    for (int i = 0; i < 8 && gnt == '0; i++) step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", gnt, '0);
    chk("midrst_done", done, '0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", op_count, 0);
    model_reset();
    req = '0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("midrst_no_done", done, '0);
    end
    drive(0, 1, ADD, 8'd2, 8'd2);
    serve("post_rst_add");

    // Randomized contention; long enough to saturate the counter.
    for (int it = 0; it < 16; it++) begin
      logic [NREQ-1:0] rq;
      rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int r = 0; r < NREQ; r++) begin
        if (rq[r]) begin
          logic [3:0] op;
          op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(1, 3));
          drive(r, 1, op, 8'($urandom), 8'($urandom));
        end
      end
      while (req != '0) serve($sformatf("rnd%0d", it));
      if ($urandom_range(0, 1) == 1) step();
    end
    chk("count_saturated", op_count, (1 << CNT_W) - 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
